id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU.
- Captures decoded instruction fields from ID each cycle.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and drives the ALU's alu_control, scr_a and scr_b.
- Detects load-use hazards, raises a stall to hold IF/ID, and injects a bubble into EX.

Parameters:
DATA_W, 32, operand/data width
REG_AW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  source register A index
id_rt  in  REG_AW  source register B index
id_uses_rt  in  1  instruction reads rt as an operand (R-type, store, beq)
id_dst  in  REG_AW  destination register index
id_rd1  in  DATA_W  register-file read data A
id_rd2  in  DATA_W  register-file read data B
id_imm  in  DATA_W  sign-extended immediate
id_alu_src  in  1  1: scr_b = immediate
id_alu_control  in  3  ALU op, passed through unchanged
id_reg_write  in  1  writes a register
id_mem_to_reg  in  1  load instruction
id_mem_write  in  1  store instruction
id_branch  in  1  branch instruction
flush  in  1  squash the instruction entering EX (taken branch)
mem_reg_write  in  1  MEM-stage instruction writes a register
mem_dst  in  REG_AW  MEM-stage destination
mem_result  in  DATA_W  MEM-stage ALU result
wb_reg_write  in  1  WB-stage instruction writes a register
wb_dst  in  REG_AW  WB-stage destination
wb_result  in  DATA_W  WB-stage write-back data
stall  out  1  hold PC and IF/ID this cycle
alu_control  out  3  to ALU
scr_a  out  DATA_W  to ALU operand A
scr_b  out  DATA_W  to ALU operand B
ex_store_data  out  DATA_W  forwarded rt value, for stores
ex_valid  out  1  EX holds a real instruction
ex_dst  out  REG_AW  EX destination
ex_reg_write  out  1  EX control bit
ex_mem_to_reg  out  1  EX control bit
ex_mem_write  out  1  EX control bit
ex_branch  out  1  EX control bit

Behaviour:
- EX register set: valid, rs, rt, dst, rd1, rd2, imm, alu_src, alu_control, reg_write, mem_to_reg, mem_write, branch. All are updated on the rising edge of clk.
- Update priority, highest first:
  - reset: all fields cleared to 0.
  - flush: bubble.
  - stall: bubble.
  - otherwise: capture all id_* inputs.
- Bubble: valid, reg_write, mem_to_reg, mem_write and branch are 0; alu_control is 3'b010 (add); data fields are don't-care and cleared to 0.
- Load-use stall, combinational:
  - stall = ex_valid & ex_mem_to_reg & (ex_dst != 0) & id_valid & ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt))).
  - stall is forced to 0 while reset or flush is high.
  - Stall is exactly one cycle per hazard. On the next cycle the load is in MEM and the EX bubble cannot trigger a stall.
- Forwarding for operand A (rs), combinational from the EX registers:
  - if mem_reg_write & mem_dst != 0 & mem_dst == ex_rs: use mem_result;
  - else if wb_reg_write & wb_dst != 0 & wb_dst == ex_rs: use wb_result;
  - else: use ex_rd1.
  - MEM has priority over WB because it holds the newer value.
- Forwarding for operand B (rt): same rules, selecting from ex_rd2.
- Register 0 is never forwarded.
- Outputs:
  - scr_a = fwdA.
  - scr_b = ex_alu_src ? ex_imm : fwdB.
  - ex_store_data = fwdB, independent of alu_src.
  - alu_control = ex_alu_control.
- Latency: an ID instruction reaches the ALU inputs one cycle after its capture edge. Forwarding paths are zero-cycle (combinational).
- Reset state: every output is 0 except alu_control = 3'b000. With all reg_write inputs low, scr_a, scr_b and ex_store_data are 0.
- Flush and stall in the same cycle: the flush bubble wins. stall is 0, so IF/ID does not hold.
- No bypass from the EX stage to itself: a dependent in the next cycle takes the value through the MEM path.
- Loads are never forwarded from MEM. The load-use stall guarantees the load's data arrives through the WB path.

Test Plan:
- Reset: assert reset for 2 cycles with random id_* inputs -> all ex_* outputs, scr_a, scr_b and stall are 0; alu_control = 0.
- Plain capture: id_rs=1, id_rd1=5, id_rd2=7, id_alu_src=0, id_alu_control=3'b010, no forwarding -> next cycle scr_a=5, scr_b=7, alu_control=010. With id_alu_src=1 and id_imm=0xFFFFFFFC -> scr_b=0xFFFFFFFC, ex_store_data=7.
- Forward priority: ex_rs=3; mem_dst=3, mem_result=0x11; wb_dst=3, wb_result=0x22 -> scr_a=0x11. Drop mem_reg_write -> scr_a=0x22. Set both dst=0 with ex_rs=0 -> scr_a=ex_rd1.
- Load-use: lw $2 in EX; ID add $4,$2,$3 -> stall=1 for exactly one cycle and ex_valid=0 the next cycle. Then the add enters EX with wb_dst=2, wb_result=0xABCD -> scr_a=0xABCD.
- id_uses_rt gating: load to $5 in EX, ID is addi with id_rt=5, id_uses_rt=0 -> stall=0.
- Flush during hazard: load-use hazard present and flush=1 -> stall=0; next cycle ex_valid=0, ex_reg_write=0, ex_mem_write=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use
// hazard detection. Feeds the ALU operands and control for the EX stage.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_control,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] scr_a,
  output logic [DATA_W-1:0] scr_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_branch
);

  localparam logic [2:0] ALU_ADD = 3'b010;

  // EX-stage register set
  logic                     vld_p1;
  logic [REG_AW-1:0]        rs_p1;
  logic [REG_AW-1:0]        rt_p1;
  logic [REG_AW-1:0]        dst_p1;
  logic signed [DATA_W-1:0] rd1_p1;
  logic signed [DATA_W-1:0] rd2_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic                     alu_src_p1;
  logic [2:0]               alu_control_p1;
  logic                     reg_write_p1;
  logic                     mem_to_reg_p1;
  logic                     mem_write_p1;
  logic                     branch_p1;

  logic signed [DATA_W-1:0] fwd_a;
  logic signed [DATA_W-1:0] fwd_b;
  logic                     raw_hazard;

  // MEM holds the newer value, so it wins over WB; $0 is hardwired and never bypassed.
  function automatic logic signed [DATA_W-1:0] fwd_sel(
    input logic [REG_AW-1:0]        src,
    input logic signed [DATA_W-1:0] rf_val,
    input logic                     m_we,
    input logic [REG_AW-1:0]        m_dst,
    input logic signed [DATA_W-1:0] m_val,
    input logic                     w_we,
    input logic [REG_AW-1:0]        w_dst,
    input logic signed [DATA_W-1:0] w_val
  );
    if (m_we && (m_dst != '0) && (m_dst == src))
      return m_val;
    else if (w_we && (w_dst != '0) && (w_dst == src))
      return w_val;
    else
      return rf_val;
  endfunction

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    raw_hazard = vld_p1 && mem_to_reg_p1 && (dst_p1 != '0) && id_valid &&
                 ((dst_p1 == id_rs) || (id_uses_rt && (dst_p1 == id_rt)));
    stall      = raw_hazard && !reset && !flush;
  end

  // ---- ID -> EX boundary: capture, or insert a bubble on flush/stall
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1         <= 1'b0;
      rs_p1          <= '0;
      rt_p1          <= '0;
      dst_p1         <= '0;
      rd1_p1         <= '0;
      rd2_p1         <= '0;
      imm_p1         <= '0;
      alu_src_p1     <= 1'b0;
      alu_control_p1 <= 3'b000;
      reg_write_p1   <= 1'b0;
      mem_to_reg_p1  <= 1'b0;
      mem_write_p1   <= 1'b0;
      branch_p1      <= 1'b0;
    end else if (flush || stall) begin
      vld_p1         <= 1'b0;
      rs_p1          <= '0;
      rt_p1          <= '0;
      dst_p1         <= '0;
      rd1_p1         <= '0;
      rd2_p1         <= '0;
      imm_p1         <= '0;
      alu_src_p1     <= 1'b0;
      alu_control_p1 <= ALU_ADD;
      reg_write_p1   <= 1'b0;
      mem_to_reg_p1  <= 1'b0;
      mem_write_p1   <= 1'b0;
      branch_p1      <= 1'b0;
    end else begin
      vld_p1         <= id_valid;
      rs_p1          <= id_rs;
      rt_p1          <= id_rt;
      dst_p1         <= id_dst;
      rd1_p1         <= id_rd1;
      rd2_p1         <= id_rd2;
      imm_p1         <= id_imm;
      alu_src_p1     <= id_alu_src;
      alu_control_p1 <= id_alu_control;
      reg_write_p1   <= id_reg_write;
      mem_to_reg_p1  <= id_mem_to_reg;
      mem_write_p1   <= id_mem_write;
      branch_p1      <= id_branch;
    end
  end

  // ---- EX operand selection: zero-cycle bypass from MEM/WB into the ALU inputs
  always_comb begin
    fwd_a = fwd_sel(rs_p1, rd1_p1, mem_reg_write, mem_dst, mem_result,
                    wb_reg_write, wb_dst, wb_result);
    fwd_b = fwd_sel(rt_p1, rd2_p1, mem_reg_write, mem_dst, mem_result,
                    wb_reg_write, wb_dst, wb_result);
  end

  assign scr_a         = fwd_a;
  assign scr_b         = alu_src_p1 ? imm_p1 : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_control   = alu_control_p1;
  assign ex_valid      = vld_p1;
  assign ex_dst        = dst_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_to_reg = mem_to_reg_p1;
  assign ex_mem_write  = mem_write_p1;
  assign ex_branch     = branch_p1;

endmodule
